// File: rtl/btn_pkg.sv
// Shared constants for the button conditioning front end of the track controller.
package btn_pkg;

  // System clock frequency, used to turn a time window into a cycle count.
  localparam int CLK_HZ = 100_000_000;

  // 10 ms debounce window at 100 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Channel indices used when wiring press pulses into the track controller.
  localparam int BTN_CYCLE = 0;  // press pulse drives cycle_sig
  localparam int BTN_PLAY  = 1;  // press pulse drives play_sig

  // Legal debounce window limits.
  localparam int MIN_DEBOUNCE_CYCLES = 2;
  localparam int MAX_DEBOUNCE_CYCLES = 1 << 24;

  // Convert a window in microseconds to clock cycles at CLK_HZ.
  function automatic int debounce_cycles_for_us(input int us);
    return (CLK_HZ / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce counter, stable level
// register and registered press/release pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // Count value on which a persistent mismatch is accepted.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_count;
  logic          r_press;
  logic          r_release;
  logic          w_mismatch;

  assign w_mismatch = r_sync2 ^ r_stable;

  // Two back-to-back flops bring the asynchronous raw level into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive mismatch cycles; any return to the stable value restarts
  // the window, and a full window commits the new level and fires one pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stable  <= 1'b0;
      r_count   <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (!w_mismatch) begin
        r_count <= '0;
      end else if (r_count != LAST) begin
        r_count <= r_count + CW'(1);
      end else begin
        r_stable  <= r_sync2;
        r_count   <= '0;
        r_press   <= r_sync2;
        r_release <= ~r_sync2;
      end
    end
  end

  assign btn_level   = r_stable;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Converts raw bouncy push-buttons into debounced levels plus one-cycle
// press/release pulses. Channels are independent; no priority is applied.
module button_pulse_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTNS        = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  // Reject windows the counter cannot represent or that defeat debouncing.
  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_window_low
    $fatal(1, "button_pulse_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (DEBOUNCE_CYCLES > MAX_DEBOUNCE_CYCLES) begin : g_bad_window_high
    $fatal(1, "button_pulse_conditioner: DEBOUNCE_CYCLES must be <= 2^24");
  end

  // One independent conditioner per button.
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner with a 4-cycle window and two buttons.
// Stimulus pushes each expected pulse event (cycle, press, release, level)
// into exp_q; the monitor pops one entry whenever the DUT pulses.
module tb_button_pulse_conditioner;

  localparam int D   = 4;
  localparam int N   = 2;
  localparam int LAT = D + 2;  // drive at negedge cyc=t -> pulse seen at negedge cyc=t+LAT
  localparam int W   = 32 + 3 * N;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int           cyc;
  int           checks;
  int           errors;
  logic [W-1:0] exp_q[$];

  button_pulse_conditioner #(
    .NUM_BTNS       (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  // Clock and edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int at, input logic [N-1:0] pr,
                          input logic [N-1:0] rl, input logic [N-1:0] lv);
    exp_q.push_back({at[31:0], pr, rl, lv});
  endtask

  task automatic check2(input string name, input logic [N-1:0] act,
                        input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if ((btn_press | btn_release) !== '0) begin
      logic [W-1:0] e;
      int           e_cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse at cyc %0d: press %b release %b level %b",
                 cyc, btn_press, btn_release, btn_level);
      end else begin
        e     = exp_q.pop_front();
        e_cyc = int'(e[W-1:3*N]);
        checks++;
        if (cyc != e_cyc) begin
          errors++;
          $display("FAIL pulse_cycle: got %0d want %0d", cyc, e_cyc);
        end
        check2("pulse_press",   btn_press,   e[3*N-1:2*N]);
        check2("pulse_release", btn_release, e[2*N-1:N]);
        check2("pulse_level",   btn_level,   e[N-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    btn_raw = '0;
    wait_cyc(3);
    check2("reset_level",   btn_level,   2'b00);
    check2("reset_press",   btn_press,   2'b00);
    check2("reset_release", btn_release, 2'b00);
    rst_n = 1'b1;
    wait_cyc(4);

    // Clean press on button 0.
    t = cyc;
    btn_raw = 2'b01;
    push_exp(t + LAT, 2'b01, 2'b00, 2'b01);
    wait_cyc(LAT - 1);
    check2("press_level_before", btn_level, 2'b00);
    wait_cyc(2);
    check2("press_pulse_gone", btn_press,   2'b00);
    check2("press_level_held", btn_level,   2'b01);
    check2("press_no_release", btn_release, 2'b00);
    wait_cyc(6);

    // Release of button 0.
    t = cyc;
    btn_raw = 2'b00;
    push_exp(t + LAT, 2'b00, 2'b01, 2'b00);
    wait_cyc(LAT + 1);
    check2("release_level_after", btn_level, 2'b00);
    wait_cyc(6);

    // Bounce 1,0,1,0 then hold 1.
    btn_raw = 2'b01; wait_cyc(1);
    btn_raw = 2'b00; wait_cyc(1);
    btn_raw = 2'b01; wait_cyc(1);
    btn_raw = 2'b00; wait_cyc(1);
    t = cyc;
    btn_raw = 2'b01;
    push_exp(t + LAT, 2'b01, 2'b00, 2'b01);
    wait_cyc(LAT + 1);
    check2("bounce_level", btn_level, 2'b01);
    wait_cyc(4);
    t = cyc;
    btn_raw = 2'b00;
    push_exp(t + LAT, 2'b00, 2'b01, 2'b00);
    wait_cyc(LAT + 4);

    // Short glitch on button 1: high for D-1 cycles.
    btn_raw = 2'b10;
    wait_cyc(D - 1);
    btn_raw = 2'b00;
    wait_cyc(2 * D + 2);
    check2("glitch_level", btn_level, 2'b00);

    // Simultaneous press then simultaneous release.
    t = cyc;
    btn_raw = 2'b11;
    push_exp(t + LAT, 2'b11, 2'b00, 2'b11);
    wait_cyc(LAT + 1);
    check2("simul_press_gone", btn_press, 2'b00);
    wait_cyc(3);
    t = cyc;
    btn_raw = 2'b00;
    push_exp(t + LAT, 2'b00, 2'b11, 2'b00);
    wait_cyc(LAT + 4);

    // Reset asserted at E3 of a press, released with the button still held.
    btn_raw = 2'b01;
    wait_cyc(3);
    rst_n = 1'b0;
    wait_cyc(1);
    check2("midreset_level",   btn_level,   2'b00);
    check2("midreset_press",   btn_press,   2'b00);
    check2("midreset_release", btn_release, 2'b00);
    wait_cyc(4);
    t = cyc;
    rst_n = 1'b1;
    push_exp(t + LAT, 2'b01, 2'b00, 2'b01);
    wait_cyc(LAT - 1);
    check2("postreset_level_before", btn_level, 2'b00);
    wait_cyc(2);
    check2("postreset_level", btn_level, 2'b01);
    wait_cyc(2 * D + 4);

    // Every expected pulse must have been consumed.
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d outstanding want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
